odd_qam_mapper: RTL and testbench
=================================

# odd_qam_mapper

Transmit-side odd-order constellation mapper for BPSK, 8PSK and QAM32. It accepts a framed, LSB-first bit stream in fixed-width words and regroups the bits into symbols of `iqam` bits through an internal gearbox. Each symbol is mapped to a signed I/Q pair with a ready/valid handshake on both sides. It sits ahead of the DAC/shaping chain and is the inverse of the team's odd-QAM LLR demapper, sharing its bit order and constellation labelling.

## Interface
- pIN_W, 8 — input word width in bits; fixed.
- pBUF_W, 16 — gearbox buffer width in bits; must be ≥ pIN_W + 5.
- pDAT_W, 8 — output I/Q width, signed; ≥ 7.
- iclk  in  1  clock.
- ireset_n  in  1  reset. One clock; reset is synchronous and active-low.
- iclkena  in  1  clock enable; all state holds when low.
- ival  in  1  input word valid.
- isop  in  1  first word of frame; qualified by ival.
- ieop  in  1  last word of frame; qualified by ival; may coincide with isop.
- iqam  in  4  bits per symbol (1, 3, 5); sampled only on the accepted isop word.
- idat  in  pIN_W  data; bit 0 is transmitted first.
- ordy  out  1  input ready; a word transfers on ival & ordy & iclkena.
- oval  out  1  output symbol valid.
- osop, oeop  out  1  first and last symbol of frame.
- oqam  out  4  latched frame qam.
- odat_re, odat_im  out  pDAT_W  signed symbol coordinates.
- iordy  in  1  downstream ready; a symbol transfers on oval & iordy & iclkena.

## Operation
- Level unit S = 2^(pDAT_W-4). With pDAT_W = 8, S = 16.
- Gearbox:
  - Bit buffer `buf` and count `cnt` (0..pBUF_W). An accepted word is appended at bit position `cnt`.
  - Emitting a symbol consumes q = latched qam bits from bit 0, shifts the buffer right by q, and sets cnt -= q.
  - On the same edge, accept and emit give cnt' = cnt - q + pIN_W.
- ordy = ireset_n & !eop_pend & (cnt ≤ pBUF_W - pIN_W). It is combinational from registers.
- eop_pend is set on an accepted ieop word and cleared when the oeop symbol is loaded.
- Emit condition: (!oval | iordy) and (cnt ≥ q, or eop_pend & cnt > 0).
  - Tail flush: when fewer than q bits remain, pad the missing high bits with 0 and raise oeop.
  - When the frame ends exactly on a symbol boundary, oeop goes on the symbol that consumes the last bit.
- osop goes on the first symbol emitted after an accepted isop.
- If isop arrives while a frame is still draining, ordy is already 0 (eop_pend), so no overlap is possible.
- Unsupported iqam (not 1, 3 or 5): the frame's words are accepted and discarded, with no output.
- Mapping uses symbol bits b0 (oldest) upward:
  - BPSK: re = b0 ? -5S : +5S; im = 0.
  - 8PSK:
    - k = {b2, b2^b1, b2^b1^b0} (Gray decode); phase = (2k+1)·π/8, radius 5S.
    - Constants: C1 = round(5S·cos π/8), C2 = round(5S·sin π/8); with pDAT_W = 8, C1 = 74 and C2 = 31.
    - Points for k = 0..7: (C1,C2), (C2,C1), (-C2,C1), (-C1,C2), (-C1,-C2), (-C2,-C1), (C2,-C1), (C1,-C2).
  - QAM32 (cross):
    - Signs: b0 = 1 makes re negative; b1 = 1 makes im negative.
    - Magnitude index {b4,b3,b2} = 0..7 selects (1,1), (3,1), (1,3), (3,3), (5,1), (5,3), (1,5), (3,5), each multiplied by S.
- The output register holds all fields while oval & !iordy.

## Timing
- Reset (ireset_n low at an edge with iclkena high): oval, osop, oeop = 0; odat_re, odat_im, oqam = 0; cnt = 0; eop_pend = 0; ordy = 0.
- Reset mid-frame drops all buffered bits; the next frame must begin with isop.
- Latency:
  - A word accepted at edge E0 can drive oval high after edge E0+1 (one register stage for the gearbox, one for the output).
  - Sustained throughput is one symbol per clock while cnt ≥ q.
  - BPSK is input-limited: 8 symbols per word.
- iclkena low freezes everything, including the handshake qualification.

## Test plan
- BPSK, single word isop = ieop = 1, idat = 0xA5, iordy = 1 → 8 symbols with re = -80, +80, -80, +80, +80, -80, +80, -80 and im = 0; osop on the 1st symbol, oeop on the 8th.
- 8PSK, one word 0xFA with isop = ieop = 1 → (-74,31), (-31,-74), then the padded tail 3'b011 gives (-31,74) with oeop.
- QAM32, symbol bits b4..b0 = 10110 → (80,-48). Also cover 8 words back-to-back with exact flush: 64 bits → 12 full symbols plus one 4-bit padded symbol carrying oeop; check ordy stays high except when cnt > 8.
- Backpressure: hold iordy = 0 for 5 cycles mid-frame → output fields stable, cnt saturates, ordy drops to 0, and no bits are lost or duplicated against a golden model.
- Reset: assert ireset_n = 0 for 1 cycle mid-QAM32 frame → next cycle oval = 0 and ordy = 0; after release, a new isop frame with qam = 3 maps correctly with no leftover bits.
- iqam = 7 frame → no oval; the following qam = 1 frame is output normally.

Source files
------------

// File: rtl/odd_qam_mapper.sv
// Odd-order constellation mapper (BPSK / 8PSK / QAM32): LSB-first bit gearbox feeding
// a registered I/Q symbol stage, ready/valid on both sides.
module odd_qam_mapper #(
   parameter int pIN_W  = 8,
   parameter int pBUF_W = 16,
   parameter int pDAT_W = 8
) (
   input  logic                     iclk,
   input  logic                     ireset_n,
   input  logic                     iclkena,
   input  logic                     ival,
   input  logic                     isop,
   input  logic                     ieop,
   input  logic [3:0]               iqam,
   input  logic [pIN_W-1:0]         idat,
   output logic                     ordy,
   output logic                     oval,
   output logic                     osop,
   output logic                     oeop,
   output logic [3:0]               oqam,
   output logic signed [pDAT_W-1:0] odat_re,
   output logic signed [pDAT_W-1:0] odat_im,
   input  logic                     iordy
);

   localparam int CNT_W = $clog2(pBUF_W + 1);
   localparam int S     = 1 << (pDAT_W - 4);
   localparam int L5    = 5 * S;
   // 60547/65536 ~ cos(pi/8), 25080/65536 ~ sin(pi/8), rounded to nearest
   localparam int C1    = (L5 * 60547 + 32768) >>> 16;
   localparam int C2    = (L5 * 25080 + 32768) >>> 16;

   localparam logic signed [pDAT_W-1:0] P5  = pDAT_W'(L5);
   localparam logic signed [pDAT_W-1:0] N5  = pDAT_W'(-L5);
   localparam logic signed [pDAT_W-1:0] PC1 = pDAT_W'(C1);
   localparam logic signed [pDAT_W-1:0] NC1 = pDAT_W'(-C1);
   localparam logic signed [pDAT_W-1:0] PC2 = pDAT_W'(C2);
   localparam logic signed [pDAT_W-1:0] NC2 = pDAT_W'(-C2);
   localparam logic signed [pDAT_W-1:0] M1  = pDAT_W'(S);
   localparam logic signed [pDAT_W-1:0] M3  = pDAT_W'(3 * S);
   localparam logic signed [pDAT_W-1:0] M5  = pDAT_W'(5 * S);

   function automatic logic qam_supported(input logic [3:0] qam);
      return (qam == 4'd1) || (qam == 4'd3) || (qam == 4'd5);
   endfunction

   logic [pBUF_W-1:0]        bit_buf, buf_next, shifted, word_ext;
   logic [CNT_W-1:0]         cnt, cnt_next, base, q, consumed;
   logic [3:0]               qam_lat;
   logic                     qam_ok, eop_pend, sop_pend;
   logic                     accept, store, emit, last;
   logic [2:0]               k, mag_idx;
   logic signed [pDAT_W-1:0] map_re, map_im, mag_re, mag_im;

   always_comb begin
      case (qam_lat)
         4'd3:    q = CNT_W'(3);
         4'd5:    q = CNT_W'(5);
         default: q = CNT_W'(1);
      endcase
   end

   assign ordy   = ireset_n & ~eop_pend & (cnt <= CNT_W'(pBUF_W - pIN_W));
   assign accept = ival & ordy;
   assign store  = isop ? qam_supported(iqam) : qam_ok;
   assign emit   = qam_ok & (~oval | iordy) & ((cnt >= q) | (eop_pend & (cnt != '0)));
   assign last   = eop_pend & (cnt <= q);

   // Bits above cnt are always zero, so a short tail symbol is padded for free.
   always_comb begin
      consumed = (cnt < q) ? cnt : q;
      shifted  = emit ? (bit_buf >> q) : bit_buf;
      base     = emit ? (cnt - consumed) : cnt;
      word_ext = {{(pBUF_W - pIN_W){1'b0}}, idat};
      buf_next = shifted;
      cnt_next = base;
      if (accept && store) begin
         buf_next = shifted | (word_ext << base);
         cnt_next = base + CNT_W'(pIN_W);
      end
   end

   always_comb begin
      map_re  = '0;
      map_im  = '0;
      mag_re  = M1;
      mag_im  = M1;
      k       = {bit_buf[2], bit_buf[2] ^ bit_buf[1], bit_buf[2] ^ bit_buf[1] ^ bit_buf[0]};
      mag_idx = bit_buf[4:2];
      case (mag_idx)
         3'd0: begin mag_re = M1; mag_im = M1; end
         3'd1: begin mag_re = M3; mag_im = M1; end
         3'd2: begin mag_re = M1; mag_im = M3; end
         3'd3: begin mag_re = M3; mag_im = M3; end
         3'd4: begin mag_re = M5; mag_im = M1; end
         3'd5: begin mag_re = M5; mag_im = M3; end
         3'd6: begin mag_re = M1; mag_im = M5; end
         default: begin mag_re = M3; mag_im = M5; end
      endcase
      case (qam_lat)
         4'd1: map_re = bit_buf[0] ? N5 : P5;
         4'd3: begin
            case (k)
               3'd0: begin map_re = PC1; map_im = PC2; end
               3'd1: begin map_re = PC2; map_im = PC1; end
               3'd2: begin map_re = NC2; map_im = PC1; end
               3'd3: begin map_re = NC1; map_im = PC2; end
               3'd4: begin map_re = NC1; map_im = NC2; end
               3'd5: begin map_re = NC2; map_im = NC1; end
               3'd6: begin map_re = PC2; map_im = NC1; end
               default: begin map_re = PC1; map_im = NC2; end
            endcase
         end
         4'd5: begin
            map_re = bit_buf[0] ? -mag_re : mag_re;
            map_im = bit_buf[1] ? -mag_im : mag_im;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (iclkena) begin
         if (!ireset_n) begin
            bit_buf  <= '0;
            cnt      <= '0;
            qam_lat  <= '0;
            qam_ok   <= 1'b0;
            eop_pend <= 1'b0;
            sop_pend <= 1'b0;
            oval     <= 1'b0;
            osop     <= 1'b0;
            oeop     <= 1'b0;
            oqam     <= '0;
            odat_re  <= '0;
            odat_im  <= '0;
         end else begin
            bit_buf <= buf_next;
            cnt     <= cnt_next;
            if (accept && isop) begin
               qam_lat <= iqam;
               qam_ok  <= qam_supported(iqam);
            end
            if (accept && store && ieop)
               eop_pend <= 1'b1;
            else if (emit && last)
               eop_pend <= 1'b0;
            if (accept && isop && qam_supported(iqam))
               sop_pend <= 1'b1;
            else if (emit)
               sop_pend <= 1'b0;
            if (emit) begin
               oval    <= 1'b1;
               osop    <= sop_pend;
               oeop    <= last;
               oqam    <= qam_lat;
               odat_re <= map_re;
               odat_im <= map_im;
            end else if (iordy) begin
               oval <= 1'b0;
               osop <= 1'b0;
               oeop <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_odd_qam_mapper.sv
// Self-checking bench for odd_qam_mapper: spec-level symbol model plus scoreboard,
// directed corner cases and randomized frames with backpressure and clock-enable gaps.
module tb_odd_qam_mapper;

   localparam int  S  = 16;
   localparam real PI = 3.14159265358979;

   logic              iclk, ireset_n, iclkena, ival, isop, ieop, iordy;
   logic [3:0]        iqam, oqam;
   logic [7:0]        idat;
   logic              ordy, oval, osop, oeop;
   logic signed [7:0] odat_re, odat_im;

   typedef struct {int re; int im; int sop; int eop; int qam;} sym_t;
   sym_t exp_q[$];

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  score_en = 1;
   bit  bp_rand  = 0;
   bit  en_rand  = 0;
   bit  iordy_set = 1;

   odd_qam_mapper #(.pIN_W(8), .pBUF_W(16), .pDAT_W(8)) dut (
      .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena),
      .ival(ival), .isop(isop), .ieop(ieop), .iqam(iqam), .idat(idat),
      .ordy(ordy), .oval(oval), .osop(osop), .oeop(oeop), .oqam(oqam),
      .odat_re(odat_re), .odat_im(odat_im), .iordy(iordy)
   );

   initial begin
      iclk = 0;
      forever #5 iclk = ~iclk;
   end

   task automatic checkOutput(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   function automatic void map_ref(input int qam, input int v, output int re, output int im);
      int  b[5];
      int  kk;
      real r, ph;
      int  mre[8] = '{1, 3, 1, 3, 5, 5, 1, 3};
      int  mim[8] = '{1, 1, 3, 3, 1, 3, 5, 5};
      for (int j = 0; j < 5; j++) b[j] = (v >> j) & 1;
      re = 0;
      im = 0;
      if (qam == 1) begin
         re = b[0] ? -5 * S : 5 * S;
      end else if (qam == 3) begin
         kk = b[2] * 4 + (b[2] ^ b[1]) * 2 + (b[2] ^ b[1] ^ b[0]);
         ph = (2 * kk + 1) * PI / 8.0;
         r  = 5.0 * S * $cos(ph);
         re = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
         r  = 5.0 * S * $sin(ph);
         im = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
      end else begin
         kk = b[2] + 2 * b[3] + 4 * b[4];
         re = (b[0] ? -1 : 1) * mre[kk] * S;
         im = (b[1] ? -1 : 1) * mim[kk] * S;
      end
   endfunction

   // Whole-frame reference: flatten words LSB first, chop into qam-bit groups, zero-pad the tail.
   task automatic modelFrame(input int qam, input logic [7:0] words[$]);
      int   bits[$];
      int   nsym, v, idx;
      sym_t e;
      foreach (words[w])
         for (int i = 0; i < 8; i++) bits.push_back(int'(words[w][i]));
      if (qam != 1 && qam != 3 && qam != 5) return;
      nsym = (bits.size() + qam - 1) / qam;
      for (int s = 0; s < nsym; s++) begin
         v = 0;
         for (int j = 0; j < qam; j++) begin
            idx = s * qam + j;
            if (idx < bits.size()) v |= bits[idx] << j;
         end
         map_ref(qam, v, e.re, e.im);
         e.sop = (s == 0);
         e.eop = (s == nsym - 1);
         e.qam = qam;
         exp_q.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic sop, input logic eop, input logic [3:0] qam,
                                input logic [7:0] dat);
      int waited = 0;
      bit done   = 0;
      ival = 1; isop = sop; ieop = eop; iqam = qam; idat = dat;
      while (!done) begin
         @(negedge iclk);
         if (ordy && iclkena) done = 1;
         else if (++waited > 300) begin
            checkOutput("accept_timeout", 0, 1);
            done = 1;
         end
      end
      @(posedge iclk); #1;
      ival = 0; isop = 0; ieop = 0;
   endtask

   task automatic driveFrame(input int qam, input logic [7:0] words[$], input bit with_eop);
      foreach (words[w])
         applyStimulus(w == 0, with_eop && (w == words.size() - 1), 4'(qam), words[w]);
   endtask

   task automatic sendFrame(input int qam, input logic [7:0] words[$]);
      modelFrame(qam, words);
      driveFrame(qam, words, 1'b1);
   endtask

   task automatic waitDrain();
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge iclk);
         n++;
      end
      repeat (4) @(negedge iclk);
      checkOutput("drain_left", exp_q.size(), 0);
      @(posedge iclk); #1;
   endtask

   initial begin
      iordy   = 1;
      iclkena = 1;
      forever begin
         @(posedge iclk); #2;
         iordy   = bp_rand ? ($urandom_range(0, 3) != 0) : iordy_set;
         iclkena = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
   end

   initial begin
      sym_t e;
      forever begin
         @(negedge iclk);
         if (score_en && ireset_n && oval && iordy && iclkena) begin
            if (exp_q.size() == 0) checkOutput("spurious_symbol", 1, 0);
            else begin
               e = exp_q.pop_front();
               checkOutput("sym_re", int'(odat_re), e.re);
               checkOutput("sym_im", int'(odat_im), e.im);
               checkOutput("sym_sop", int'(osop), e.sop);
               checkOutput("sym_eop", int'(oeop), e.eop);
               checkOutput("sym_qam", int'(oqam), e.qam);
            end
         end
      end
   end

   initial begin
      logic [7:0]        words[$];
      logic signed [7:0] h_re, h_im;
      logic              h_sop, h_eop;
      int                qam, nw, n;

      ireset_n = 0; ival = 0; isop = 0; ieop = 0; iqam = 0; idat = 0;
      repeat (3) @(posedge iclk);
      @(negedge iclk);
      checkOutput("rst_oval", int'(oval), 0);
      checkOutput("rst_osop", int'(osop), 0);
      checkOutput("rst_oeop", int'(oeop), 0);
      checkOutput("rst_re", int'(odat_re), 0);
      checkOutput("rst_im", int'(odat_im), 0);
      checkOutput("rst_oqam", int'(oqam), 0);
      checkOutput("rst_ordy", int'(ordy), 0);
      @(posedge iclk); #1;
      ireset_n = 1;
      @(negedge iclk);
      checkOutput("ordy_after_rst", int'(ordy), 1);
      @(posedge iclk); #1;

      $display("[TB] BPSK single word 0xA5");
      words = '{8'hA5};
      sendFrame(1, words);
      @(negedge iclk);
      checkOutput("latency_e0", int'(oval), 0);
      @(negedge iclk);
      checkOutput("latency_e1", int'(oval), 1);
      waitDrain();

      $display("[TB] 8PSK single word 0xFA");
      words = '{8'hFA};
      sendFrame(3, words);
      waitDrain();

      $display("[TB] QAM32 word carrying 10110");
      words = '{8'h16};
      sendFrame(5, words);
      waitDrain();

      $display("[TB] QAM32 eight words back-to-back");
      words.delete();
      for (int i = 0; i < 8; i++) words.push_back(8'($urandom));
      sendFrame(5, words);
      waitDrain();

      $display("[TB] Backpressure mid-frame");
      words.delete();
      for (int i = 0; i < 6; i++) words.push_back(8'($urandom));
      modelFrame(5, words);
      fork
         driveFrame(5, words, 1'b1);
         begin
            n = 0;
            do begin
               @(negedge iclk);
               n++;
            end while (!oval && n < 100);
            checkOutput("stall_oval_seen", int'(oval), 1);
            @(posedge iclk); #1;
            iordy_set = 0;
            @(negedge iclk);
            h_re = odat_re; h_im = odat_im; h_sop = osop; h_eop = oeop;
            checkOutput("stall_oval", int'(oval), 1);
            repeat (4) begin
               @(negedge iclk);
               checkOutput("stall_hold_oval", int'(oval), 1);
               checkOutput("stall_hold_re", int'(odat_re), int'(h_re));
               checkOutput("stall_hold_im", int'(odat_im), int'(h_im));
               checkOutput("stall_hold_sop", int'(osop), int'(h_sop));
               checkOutput("stall_hold_eop", int'(oeop), int'(h_eop));
            end
            checkOutput("stall_ordy_low", int'(ordy), 0);
            @(posedge iclk); #1;
            iordy_set = 1;
         end
      join
      waitDrain();

      $display("[TB] Reset mid QAM32 frame");
      score_en = 0;
      words = '{8'h3C, 8'hD2};
      driveFrame(5, words, 1'b0);
      repeat (2) @(posedge iclk);
      #1;
      ireset_n = 0;
      @(negedge iclk);
      checkOutput("midrst_ordy", int'(ordy), 0);
      @(posedge iclk); #1;
      ireset_n = 1;
      @(negedge iclk);
      checkOutput("midrst_oval", int'(oval), 0);
      checkOutput("midrst_osop", int'(osop), 0);
      checkOutput("midrst_ordy_rel", int'(ordy), 1);
      exp_q.delete();
      score_en = 1;
      @(posedge iclk); #1;
      words = '{8'h5B, 8'hE1};
      sendFrame(3, words);
      waitDrain();

      $display("[TB] Unsupported qam 7 then BPSK");
      words = '{8'hFF, 8'h81};
      sendFrame(7, words);
      words = '{8'h69};
      sendFrame(1, words);
      waitDrain();

      $display("[TB] Randomized frames");
      bp_rand = 1;
      en_rand = 1;
      for (int f = 0; f < 16; f++) begin
         n   = $urandom_range(0, 2);
         qam = (n == 0) ? 1 : (n == 1) ? 3 : 5;
         nw  = $urandom_range(1, 5);
         words.delete();
         for (int i = 0; i < nw; i++) words.push_back(8'($urandom));
         sendFrame(qam, words);
      end
      waitDrain();
      bp_rand = 0;
      en_rand = 0;
      repeat (2) @(posedge iclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
